// File: rtl/sync_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctl
// Description : Single-clock parametrised FIFO with occupancy count,
//               almost-full/almost-empty thresholds, synchronous flush,
//               sticky overflow/underflow flags and a selectable standard
//               (registered, latency 1) or first-word-fall-through read port.
// Ports       : i_clk, i_rst (async, active-high), i_flush, i_wren/i_wrdata,
//               i_rden, i_clr_err -> o_rddata, o_full, o_empty, o_afull,
//               o_aempty, o_count, o_overflow, o_underflow
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctl #(
  parameter int P_WIDTH  = 8,
  parameter int P_DEPTH  = 16,
  parameter int P_AFULL  = 12,
  parameter int P_AEMPTY = 2,
  parameter int P_FWFT   = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_wren,
  input  logic [P_WIDTH-1:0]         i_wrdata,
  input  logic                       i_rden,
  input  logic                       i_clr_err,
  output logic [P_WIDTH-1:0]         o_rddata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_afull,
  output logic                       o_aempty,
  output logic [$clog2(P_DEPTH):0]   o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int C_ADDR_W = $clog2(P_DEPTH);
  localparam int C_CNT_W  = C_ADDR_W + 1;

  logic [P_WIDTH-1:0]  r_mem [P_DEPTH];
  logic [C_ADDR_W-1:0] r_wr_ptr;
  logic [C_ADDR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0]  r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wa;
  logic w_ra;
  logic w_ovf_set;
  logic w_udf_set;

  // All status flags decode from the registered count only, so they move
  // on the edge after the causing operation.
  assign w_full    = (r_count == C_CNT_W'(P_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_wa      = i_wren & ~w_full  & ~i_flush;
  assign w_ra      = i_rden & ~w_empty & ~i_flush;
  assign w_ovf_set = i_wren & w_full  & ~i_flush;
  assign w_udf_set = i_rden & w_empty & ~i_flush;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wa) begin
      r_mem[r_wr_ptr] <= i_wrdata;
    end
  end

  // Pointers wrap naturally at P_DEPTH because P_DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wa) begin
        r_wr_ptr <= r_wr_ptr + C_ADDR_W'(1);
      end
      if (w_ra) begin
        r_rd_ptr <= r_rd_ptr + C_ADDR_W'(1);
      end
      case ({w_wa, w_ra})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_udf_set) begin
        r_underflow <= 1'b1;
      end else if (i_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (P_FWFT != 0) begin : g_fwft
      // Head word is shown combinationally from memory; zero while empty.
      assign o_rddata = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [P_WIDTH-1:0] r_rddata;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_rddata <= '0;
        end else if (w_ra) begin
          r_rddata <= r_mem[r_rd_ptr];
        end
      end
      assign o_rddata = r_rddata;
    end
  endgenerate

  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_afull     = (r_count >= C_CNT_W'(P_AFULL));
  assign o_aempty    = (r_count <= C_CNT_W'(P_AEMPTY));
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctl
// Description : Self-checking bench for sync_fifo_ctl. One standard-mode and
//               one FWFT-mode instance share a stimulus stream; a queue-based
//               model supplies the expected outputs of both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctl;

  localparam int W      = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         wren;
  logic [W-1:0] wrdata;
  logic         rden;
  logic         clr_err;

  logic [W-1:0] s_rddata, f_rddata;
  logic         s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic         f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0]   s_count, f_count;

  sync_fifo_ctl #(.P_WIDTH(W), .P_DEPTH(DEPTH), .P_AFULL(AFULL),
                  .P_AEMPTY(AEMPTY), .P_FWFT(0)) u_std (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wren(wren),
    .i_wrdata(wrdata), .i_rden(rden), .i_clr_err(clr_err),
    .o_rddata(s_rddata), .o_full(s_full), .o_empty(s_empty),
    .o_afull(s_afull), .o_aempty(s_aempty), .o_count(s_count),
    .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  sync_fifo_ctl #(.P_WIDTH(W), .P_DEPTH(DEPTH), .P_AFULL(AFULL),
                  .P_AEMPTY(AEMPTY), .P_FWFT(1)) u_fwft (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_wren(wren),
    .i_wrdata(wrdata), .i_rden(rden), .i_clr_err(clr_err),
    .o_rddata(f_rddata), .o_full(f_full), .o_empty(f_empty),
    .o_afull(f_afull), .o_aempty(f_aempty), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO contents as a plain queue.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_std_rd;
  logic         m_ovf;
  logic         m_udf;
  bit           cmp_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_std_rd = '0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endfunction

  function automatic logic [W-1:0] m_head();
    return (m_q.size() == 0) ? '0 : m_q[0];
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  function automatic void m_step();
    bit full, empty, ovf_set, udf_set;
    full    = (m_q.size() == DEPTH);
    empty   = (m_q.size() == 0);
    ovf_set = wren && full && !flush;
    udf_set = rden && empty && !flush;
    if (flush) begin
      m_q.delete();
    end else begin
      if (rden && !empty) m_std_rd = m_q.pop_front();
      if (wren && !full)  m_q.push_back(wrdata);
    end
    m_ovf = ovf_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_udf = udf_set ? 1'b1 : (clr_err ? 1'b0 : m_udf);
  endfunction

  // Every cycle, away from the active edge, compare both instances.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("s_count",  32'(s_count),  32'(m_q.size()));
      chk("s_full",   32'(s_full),   32'(m_q.size() == DEPTH));
      chk("s_empty",  32'(s_empty),  32'(m_q.size() == 0));
      chk("s_afull",  32'(s_afull),  32'(m_q.size() >= AFULL));
      chk("s_aempty", 32'(s_aempty), 32'(m_q.size() <= AEMPTY));
      chk("s_ovf",    32'(s_ovf),    32'(m_ovf));
      chk("s_udf",    32'(s_udf),    32'(m_udf));
      chk("s_rddata", 32'(s_rddata), 32'(m_std_rd));
      chk("f_count",  32'(f_count),  32'(m_q.size()));
      chk("f_full",   32'(f_full),   32'(m_q.size() == DEPTH));
      chk("f_empty",  32'(f_empty),  32'(m_q.size() == 0));
      chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
      chk("f_udf",    32'(f_udf),    32'(m_udf));
      chk("f_rddata", 32'(f_rddata), 32'(m_head()));
    end
  end

  // Drive one cycle of inputs, let the edge happen, then update the model.
  task automatic cyc(input logic fl, input logic w, input logic [W-1:0] d,
                     input logic r, input logic c);
    flush = fl; wren = w; wrdata = d; rden = r; clr_err = c;
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wren = 1'b0; wrdata = '0; rden = 1'b0; clr_err = 1'b0;
    m_reset();
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(s_count), 32'd0);
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_aempty", 32'(s_aempty), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_rddata", 32'(s_rddata), 32'd0);
    rst = 1'b0;
    idle();

    // Read while empty, clear, then clear together with an empty read.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(s_udf), 32'd1);
    chk("udf_rddata", 32'(s_rddata), 32'h00);
    chk("udf_count", 32'(s_count), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", 32'(s_udf), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_set_wins", 32'(s_udf), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Fill with 0x01..0x10, overflow, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_afull", 32'(s_afull), 32'(i >= 12));
    end
    chk("fill_count", 32'(s_count), 32'd16);
    chk("fill_full", 32'(s_full), 32'd1);
    cyc(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_rddata", 32'(s_rddata), 32'(i));
    end
    chk("drain_empty", 32'(s_empty), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Steady write+read at count 3, wrapping the pointers.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
      chk("wrap_count", 32'(s_count), 32'd3);
      chk("wrap_rddata", 32'(s_rddata), (i < 3) ? 32'(8'hA0 + i) : 32'(8'hB0 + i - 3));
    end
    chk("wrap_noerr", 32'({s_ovf, s_udf}), 32'd0);

    // Write+read when full: read wins, 0x55 never stored.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullrw_count", 32'(s_count), 32'd15);
    chk("fullrw_rddata", 32'(s_rddata), 32'h60);
    chk("fullrw_ovf", 32'(s_ovf), 32'd1);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("fullrw_drain", 32'(s_rddata), 32'(8'h60 + i));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Flush at count 7 with concurrent requests.
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    chk("pre_flush_count", 32'(s_count), 32'd7);
    cyc(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("flush_count", 32'(s_count), 32'd0);
    chk("flush_empty", 32'(s_empty), 32'd1);
    chk("flush_aempty", 32'(s_aempty), 32'd1);
    chk("flush_noerr", 32'({s_ovf, s_udf}), 32'd0);
    chk("flush_rddata", 32'(s_rddata), 32'h6F);
    chk("flush_fwft", 32'(f_rddata), 32'h00);

    // FWFT: word visible after its write edge; acknowledge empties.
    cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_data", 32'(f_rddata), 32'h3C);
    chk("fwft_empty", 32'(f_empty), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_ack_empty", 32'(f_empty), 32'd1);
    chk("fwft_ack_data", 32'(f_rddata), 32'h00);

    // Randomised traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 800; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      cyc(($urandom_range(99) < 2), ($urandom_range(99) < wp), 8'($urandom),
          ($urandom_range(99) < (100 - wp)), ($urandom_range(99) < 5));
    end

    // Asynchronous reset in the middle of a burst.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hE0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("arst_count", 32'(s_count), 32'd0);
    chk("arst_empty", 32'({s_empty, f_empty}), 32'd3);
    chk("arst_aempty", 32'({s_aempty, f_aempty}), 32'd3);
    chk("arst_full", 32'({s_full, f_full, s_afull, f_afull}), 32'd0);
    chk("arst_flags", 32'({s_ovf, s_udf, f_ovf, f_udf}), 32'd0);
    chk("arst_rddata", 32'({s_rddata, f_rddata}), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_rddata", 32'(s_rddata), 32'h11);
    idle();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_ctl.md
Name: sync_fifo_ctl

Overview:
Single-clock, parametrised FIFO that succeeds the dual-pointer peripheral FIFO. Adds:
- occupancy count
- programmable almost-full and almost-empty thresholds
- synchronous flush
- sticky overflow and underflow error flags
- selectable standard or first-word-fall-through (FWFT) read mode

Sits between the UART/SPI peripherals and the CPU bus slave as the data buffer and interrupt source.

Parameters:
P_WIDTH, 8, data width in bits (>=1)
P_DEPTH, 16, number of entries; power of two, >=2
P_AFULL, 12, o_afull asserted when count >= P_AFULL (1..P_DEPTH)
P_AEMPTY, 2, o_aempty asserted when count <= P_AEMPTY (0..P_DEPTH-1)
P_FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  asynchronous reset, active-high
i_flush  input  1  synchronous flush, empties FIFO
i_wren  input  1  write request
i_wrdata  input  P_WIDTH  write data
i_rden  input  1  read request (pop)
i_clr_err  input  1  clears sticky error flags
o_rddata  output  P_WIDTH  read data
o_full  output  1  count == P_DEPTH
o_empty  output  1  count == 0
o_afull  output  1  count >= P_AFULL
o_aempty  output  1  count <= P_AEMPTY
o_count  output  $clog2(P_DEPTH)+1  current occupancy
o_overflow  output  1  sticky: write attempted while full
o_underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (i_rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0
  - o_rddata=0, o_overflow=0, o_underflow=0
  - outputs therefore: o_empty=1, o_aempty=1, o_full=0, o_afull=0
  - memory not cleared
  - reset mid-operation discards all contents immediately
- Pointers are $clog2(P_DEPTH) bits and wrap P_DEPTH-1 -> 0 naturally.
- Flags are decoded only from the registered count, so they change on the clock edge after the causing operation, never combinationally from inputs.
- Write accepted (wa) = i_wren & ~o_full & ~i_flush. On wa: mem[wr_ptr] <= i_wrdata; wr_ptr+1.
- Read accepted (ra) = i_rden & ~o_empty & ~i_flush. On ra: rd_ptr+1.
- Full/empty rules:
  - Write while full is rejected: memory and pointers unchanged.
  - Read while empty is rejected: pointers unchanged. o_rddata holds in standard mode.
  - Simultaneous i_wren and i_rden when full: read accepted, write rejected, overflow sets.
  - Simultaneous i_wren and i_rden when empty: write accepted, read rejected, underflow sets.
- Count update: wa only -> +1; ra only -> -1; both or neither -> unchanged. Count never exceeds P_DEPTH and never goes below 0.
- Standard mode (P_FWFT=0):
  - On ra, o_rddata <= mem[rd_ptr]; data visible the cycle after the read (latency 1).
  - Otherwise o_rddata holds its last value.
- FWFT mode (P_FWFT=1):
  - o_rddata = mem[rd_ptr] while o_empty=0, and 0 while o_empty=1.
  - A word written at edge N is visible at o_rddata after edge N (o_empty falls at the same edge).
  - i_rden acknowledges the displayed word; the next word appears after the edge.
- Flush:
  - Has priority over wr/rd: pointers and count go to 0 at the edge.
  - o_rddata holds in standard mode, and reads 0 in FWFT mode after the flush.
  - Error flags are not affected, and a request during flush does not set them.
- Error flags:
  - o_overflow sets on i_wren & o_full & ~i_flush.
  - o_underflow sets on i_rden & o_empty & ~i_flush.
  - Both cleared by i_clr_err; a set wins over a clear in the same cycle.

Test Plan:
1. Reset, then write 0x01..0x10 (16 words) -> o_count 16, o_full=1, o_afull=1 from count 12; 17th write 0xFF rejected, o_overflow=1; read 16 in standard mode -> o_rddata 0x01..0x10, each one cycle after its read; o_empty=1 after last.
2. Read while empty (after reset) -> o_underflow=1, o_rddata stays 0x00, count stays 0; i_clr_err pulse -> o_underflow=0; i_clr_err together with an empty read -> flag stays 1.
3. Wrap: 20 cycles of write+read overlap after pre-filling 3 words (0xA0..0xA2) -> count stays 3, data returned in order across pointer wrap 15->0; no error flags.
4. Simultaneous write and read at full (count 16) -> count 15, head popped, write data 0x55 absent from later reads, o_overflow=1.
5. Flush with count 7 plus concurrent i_wren/i_rden -> count 0, o_empty=1, o_aempty=1, no error flags set, o_rddata unchanged (standard mode).
6. P_FWFT=1: write 0x3C at edge N -> o_rddata=0x3C, o_empty=0 after edge N with no i_rden; pulse i_rden -> o_empty=1, o_rddata=0x00; async i_rst mid-burst -> all outputs return to reset values immediately without a clock edge.
